loop_sequencer: RTL

//  Parametrised loop-control successor for the Potato control unit. Tracks '['/']' nesting in a

---
 rtl/loop_sequencer.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/loop_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : loop_sequencer
// Purpose  : Loop-control successor for the Potato control unit. Tracks
//            '['/']' nesting and sequences the forward skip (zero cell at '[')
//            and the backward scan (non-zero cell at ']'). An optional stack
//            of '[' addresses turns most backward scans into a one-cycle jump.
// Config   : LOOP_STACK_EN - when defined, builds the STACK_DEPTH x PC_WIDTH
//            address stack and the Jump/JumpAddr path. When undefined, Jump and
//            JumpAddr are tied to 0 and every taken ']' uses the backward scan.
// Ports    : Clock      - rising-edge clock
//            Reset      - asynchronous, active-high reset
//            InstrValid - Loop/Done/Pc valid this cycle; low holds all state
//            Loop       - current instruction is '['
//            Done       - current instruction is ']'
//            ZeroFlag   - current cell is zero
//            Pc         - address of current instruction
//            Reverse    - PC must decrement (backward scan active)
//            SkipCmd    - suppress execution of current instruction
//            Jump       - one-cycle pulse, load PC with JumpAddr
//            JumpAddr   - jump target (stacked '[' address + 1)
//            Nest       - current loop nesting level
//            Error      - sticky fault, CPU must halt
// Revision : 1.0 - initial release
// ============================================================================
module loop_sequencer #(
    parameter int PC_WIDTH    = 8,
    parameter int DEPTH_WIDTH = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   InstrValid,
    input  logic                   Loop,
    input  logic                   Done,
    input  logic                   ZeroFlag,
    input  logic [PC_WIDTH-1:0]    Pc,
    output logic                   Reverse,
    output logic                   SkipCmd,
    output logic                   Jump,
    output logic [PC_WIDTH-1:0]    JumpAddr,
    output logic [DEPTH_WIDTH-1:0] Nest,
    output logic                   Error
);

    localparam logic [1:0] c_RUN       = 2'd0;
    localparam logic [1:0] c_SKIP_FWD  = 2'd1;
    localparam logic [1:0] c_SCAN_BACK = 2'd2;
    localparam logic [1:0] c_ERROR     = 2'd3;

    localparam logic [DEPTH_WIDTH-1:0] c_ONE     = DEPTH_WIDTH'(1);
    localparam logic [DEPTH_WIDTH-1:0] c_CNT_MAX = '1;

    logic [1:0]             r_state;
    logic [DEPTH_WIDTH-1:0] r_depth;
    logic [DEPTH_WIDTH-1:0] r_nest;
    logic                   r_reverse;
    logic                   r_skip;
    logic                   r_error;

    logic [1:0]             w_state_nxt;
    logic [DEPTH_WIDTH-1:0] w_depth_nxt;
    logic [DEPTH_WIDTH-1:0] w_nest_nxt;
    logic                   w_fault;

`ifdef LOOP_STACK_EN
    localparam int c_IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [PC_WIDTH-1:0] r_stack [STACK_DEPTH];
    logic                r_jump;
    logic [PC_WIDTH-1:0] r_jump_addr;
    logic                w_push;
    logic                w_jump_nxt;
    logic                w_push_ok;
    logic                w_stack_hit;
    logic [PC_WIDTH-1:0] w_top_addr;

    // Level n ('[' taken with Nest==n) lives in entry n; levels beyond the
    // stack are not recorded and fall back to the backward scan.
    assign w_push_ok   = int'(r_nest) < STACK_DEPTH;
    assign w_stack_hit = (r_nest != '0) && (int'(r_nest) <= STACK_DEPTH);
    assign w_top_addr  = r_stack[c_IDX_W'(r_nest - c_ONE)];

    // Storage needs no reset: an entry is only read while Nest says it is live.
    always_ff @(posedge Clock) begin
        if (w_push) begin
            r_stack[c_IDX_W'(r_nest)] <= Pc;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_jump      <= 1'b0;
            r_jump_addr <= '0;
        end else begin
            r_jump <= w_jump_nxt;
            if (w_jump_nxt) begin
                r_jump_addr <= w_top_addr + PC_WIDTH'(1);
            end
        end
    end

    assign Jump     = r_jump;
    assign JumpAddr = r_jump_addr;
`else
    assign Jump     = 1'b0;
    assign JumpAddr = '0;
`endif

    // Next-state decision. Fault branches leave Nest and depth untouched so
    // the counters show the level at which the program went wrong.
    always_comb begin
        w_state_nxt = r_state;
        w_depth_nxt = r_depth;
        w_nest_nxt  = r_nest;
        w_fault     = 1'b0;
`ifdef LOOP_STACK_EN
        w_push      = 1'b0;
        w_jump_nxt  = 1'b0;
`endif
        if (InstrValid && (r_state != c_ERROR)) begin
            if (Loop && Done) begin
                w_fault = 1'b1;
            end else begin
                case (r_state)
                    c_RUN: begin
                        if (Loop) begin
                            if (r_nest == c_CNT_MAX) begin
                                w_fault = 1'b1;
                            end else if (ZeroFlag) begin
                                // Skipped loop body is never entered, so Nest stays.
                                w_state_nxt = c_SKIP_FWD;
                                w_depth_nxt = c_ONE;
                            end else begin
                                w_nest_nxt = r_nest + c_ONE;
`ifdef LOOP_STACK_EN
                                w_push     = w_push_ok;
`endif
                            end
                        end else if (Done) begin
                            if (r_nest == '0) begin
                                w_fault = 1'b1;
                            end else if (ZeroFlag) begin
                                w_nest_nxt = r_nest - c_ONE;
`ifdef LOOP_STACK_EN
                            end else if (w_stack_hit) begin
                                w_jump_nxt = 1'b1;
`endif
                            end else begin
                                w_state_nxt = c_SCAN_BACK;
                                w_depth_nxt = c_ONE;
                            end
                        end
                    end
                    c_SKIP_FWD: begin
                        if (Loop) begin
                            if (r_depth == c_CNT_MAX) begin
                                w_fault = 1'b1;
                            end else begin
                                w_depth_nxt = r_depth + c_ONE;
                            end
                        end else if (Done) begin
                            w_depth_nxt = r_depth - c_ONE;
                            if (r_depth == c_ONE) begin
                                w_state_nxt = c_RUN;
                            end
                        end
                    end
                    c_SCAN_BACK: begin
                        // Reaching address 0 without the matching '[' means the
                        // program has no opening bracket for this ']'.
                        if ((Pc == '0) && !(Loop && (r_depth == c_ONE))) begin
                            w_fault = 1'b1;
                        end else if (Done) begin
                            if (r_depth == c_CNT_MAX) begin
                                w_fault = 1'b1;
                            end else begin
                                w_depth_nxt = r_depth + c_ONE;
                            end
                        end else if (Loop) begin
                            w_depth_nxt = r_depth - c_ONE;
                            if (r_depth == c_ONE) begin
                                w_state_nxt = c_RUN;
                            end
                        end
                    end
                    default: begin
                        w_state_nxt = r_state;
                    end
                endcase
            end
            if (w_fault) begin
                w_state_nxt = c_ERROR;
            end
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state   <= c_RUN;
            r_depth   <= '0;
            r_nest    <= '0;
            r_reverse <= 1'b0;
            r_skip    <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_depth   <= w_depth_nxt;
            r_nest    <= w_nest_nxt;
            r_reverse <= (w_state_nxt == c_SCAN_BACK);
            r_skip    <= (w_state_nxt != c_RUN);
            r_error   <= (w_state_nxt == c_ERROR);
        end
    end

    assign Reverse = r_reverse;
    assign SkipCmd = r_skip;
    assign Nest    = r_nest;
    assign Error   = r_error;

endmodule
`default_nettype wire
